// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, owner ids,
// memory geometry and the address-legality rule.
package dmem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   localparam logic OWNER_CPU = 1'b0;
   localparam logic OWNER_DBG = 1'b1;

   localparam int DMEM_WORDS = 64;
   localparam int DMEM_AW    = $clog2(DMEM_WORDS);

   // Only word-aligned byte addresses inside the 256-byte window are legal.
   function automatic logic addr_err(input logic [31:0] addr);
      return (addr[1:0] != 2'b00) || (addr[31:8] != 24'd0);
   endfunction

endpackage

// File: rtl/dmem_starve_cnt.sv
// Saturating count of arbitration rounds lost by the debug port; full
// tells the arbiter the debug port must win the next contested round.
module dmem_starve_cnt #(
   parameter int LIMIT = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic inc,
   output logic full
);

   localparam int CW = $clog2(LIMIT + 1);
   localparam logic [CW-1:0] MAX = CW'(LIMIT);

   logic [CW-1:0] count;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc && (count != MAX)) begin
         count <= count + CW'(1);
      end
   end

   assign full = (count == MAX);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (pipeline + debug/loader) arbiter in front of a 64-word data
// memory; one transaction at a time, IDLE -> ACCESS -> RESP.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                cpu_req,
   input  logic                cpu_we,
   input  logic [31:0]         cpu_addr,
   input  logic [31:0]         cpu_wdata,
   output logic [31:0]         cpu_rdata,
   output logic                cpu_ack,
   output logic                cpu_err,
   output logic                cpu_stall,
   input  logic                dbg_req,
   input  logic                dbg_we,
   input  logic [31:0]         dbg_addr,
   input  logic [31:0]         dbg_wdata,
   output logic [31:0]         dbg_rdata,
   output logic                dbg_ack,
   output logic                dbg_err,
   output logic                mem_en,
   output logic                mem_we,
   output logic [DMEM_AW-1:0]  mem_addr,
   output logic [31:0]         mem_wdata,
   input  logic [31:0]         mem_rdata,
   output state_t              fsm_state
);

   // Handshake: a requester raises req with stable we/addr/wdata and holds
   // it until its one-cycle ack; err and rdata are valid only with that ack.

   state_t      state;
   logic        owner;
   logic        we_r;
   logic        err_r;
   logic        idle;
   logic        any_req;
   logic        grant_dbg;
   logic        sel_we;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic        sel_err;
   logic        starve_full;
   logic        starve_inc;
   logic        starve_clr;
   logic [31:0] resp_data;

   always_comb begin
      idle      = (state == ST_IDLE);
      any_req   = cpu_req | dbg_req;
      grant_dbg = dbg_req & (~cpu_req | starve_full);
      sel_we    = grant_dbg ? dbg_we    : cpu_we;
      sel_addr  = grant_dbg ? dbg_addr  : cpu_addr;
      sel_wdata = grant_dbg ? dbg_wdata : cpu_wdata;
      sel_err   = addr_err(sel_addr);
      starve_inc = idle & dbg_req & ~grant_dbg;
      starve_clr = ~dbg_req | (idle & grant_dbg);
      resp_data  = err_r ? 32'd0 : mem_rdata;
   end

   dmem_starve_cnt #(
      .LIMIT (STARVE_LIMIT)
   ) u_starve (
      .clock (clock),
      .reset (reset),
      .clear (starve_clr),
      .inc   (starve_inc),
      .full  (starve_full)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         owner     <= OWNER_CPU;
         we_r      <= 1'b0;
         err_r     <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         cpu_rdata <= '0;
         dbg_rdata <= '0;
         cpu_ack   <= 1'b0;
         dbg_ack   <= 1'b0;
         cpu_err   <= 1'b0;
         dbg_err   <= 1'b0;
      end else begin
         cpu_ack <= 1'b0;
         dbg_ack <= 1'b0;
         cpu_err <= 1'b0;
         dbg_err <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (any_req) begin
                  state     <= ST_ACCESS;
                  owner     <= grant_dbg ? OWNER_DBG : OWNER_CPU;
                  we_r      <= sel_we;
                  err_r     <= sel_err;
                  // A rejected address never reaches the memory.
                  mem_en    <= ~sel_err;
                  mem_we    <= sel_we & ~sel_err;
                  mem_addr  <= sel_err ? '0 : sel_addr[DMEM_AW+1:2];
                  mem_wdata <= sel_err ? '0 : sel_wdata;
               end
            end
            ST_ACCESS: begin
               state     <= ST_RESP;
               mem_en    <= 1'b0;
               mem_we    <= 1'b0;
               mem_addr  <= '0;
               mem_wdata <= '0;
               if (owner == OWNER_CPU) begin
                  cpu_ack <= 1'b1;
                  cpu_err <= err_r;
                  if (~we_r | err_r) cpu_rdata <= resp_data;
               end else begin
                  dbg_ack <= 1'b1;
                  dbg_err <= err_r;
                  if (~we_r | err_r) dbg_rdata <= resp_data;
               end
            end
            ST_RESP: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign cpu_stall = cpu_req & ~cpu_ack;
   assign fsm_state = state;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random two-port traffic,
// checked each cycle against a transaction-level model of the arbiter.
module tb_dmem_arbiter;
   import dmem_arbiter_pkg::*;

   localparam int LIMIT = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        cpu_req = 1'b0, cpu_we = 1'b0;
   logic [31:0] cpu_addr = '0, cpu_wdata = '0;
   logic [31:0] cpu_rdata;
   logic        cpu_ack, cpu_err, cpu_stall;
   logic        dbg_req = 1'b0, dbg_we = 1'b0;
   logic [31:0] dbg_addr = '0, dbg_wdata = '0;
   logic [31:0] dbg_rdata;
   logic        dbg_ack, dbg_err;
   logic        mem_en, mem_we;
   logic [5:0]  mem_addr;
   logic [31:0] mem_wdata, mem_rdata;
   state_t      fsm_state;

   dmem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clock(clock), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_stall(cpu_stall),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack), .dbg_err(dbg_err),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .fsm_state(fsm_state)
   );

   always #5 clock = ~clock;

   // Memory attached to the arbiter; pre_* loads contents from the bench.
   logic [31:0] mem [DMEM_WORDS];
   logic        pre_we = 1'b0;
   logic [5:0]  pre_idx = '0;
   logic [31:0] pre_data = '0;
   assign mem_rdata = mem[mem_addr];
   always @(posedge clock) begin
      if (pre_we) mem[pre_idx] <= pre_data;
      else if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
   end

   typedef struct {
      bit          owner;
      bit          we;
      bit          err;
      logic [5:0]  idx;
      logic [31:0] wdata;
      int          ack_cyc;
   } txn_t;
   typedef struct {
      bit          owner;
      int          cyc;
      logic [31:0] rdata;
      bit          err;
   } ack_t;

   txn_t        exp_q[$];
   ack_t        ack_log[$];
   logic [31:0] ref_mem [DMEM_WORDS];
   logic [31:0] last_rdata [2];
   int          cyc, free_cyc, starve;
   int          checks, errors;
   int          en_cnt, we_cnt;
   logic [5:0]  last_we_addr;
   bit          rand_mode, hold_mode;
   bit          cpu_acked, dbg_acked, exp_cpu_ack;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] rand_addr();
      case ($urandom_range(0, 7))
         0:       return $urandom;
         1:       return {24'd0, 4'd0, 2'($urandom_range(0, 3)), 2'($urandom_range(1, 3))};
         default: return {24'd0, 2'd0, 4'($urandom_range(0, 15)), 2'b00};
      endcase
   endfunction

   // Compare this cycle's outputs with the transaction in flight, if any.
   task automatic check_cycle();
      txn_t        t;
      bit          in_resp, in_access;
      logic [31:0] exp_rd;
      t = '{default: 0};
      if (exp_q.size() > 0) t = exp_q[0];
      in_resp   = (exp_q.size() > 0) && (t.ack_cyc == cyc);
      in_access = (exp_q.size() > 0) && (t.ack_cyc == cyc + 1);
      exp_cpu_ack = in_resp && !t.owner;
      check("fsm_state", fsm_state, in_resp ? 2 : (in_access ? 1 : 0));
      check("cpu_ack", cpu_ack, exp_cpu_ack);
      check("dbg_ack", dbg_ack, in_resp && t.owner);
      check("cpu_err", cpu_err, in_resp && !t.owner && t.err);
      check("dbg_err", dbg_err, in_resp && t.owner && t.err);
      check("mem_en", mem_en, in_access && !t.err);
      check("mem_we", mem_we, in_access && !t.err && t.we);
      if (in_access && !t.err) begin
         check("mem_addr", mem_addr, t.idx);
         if (t.we) check("mem_wdata", mem_wdata, t.wdata);
      end
      if (in_resp) begin
         exp_rd = t.err ? 32'd0 : (t.we ? last_rdata[t.owner] : ref_mem[t.idx]);
         if (!t.err && t.we) ref_mem[t.idx] = t.wdata;
         last_rdata[t.owner] = exp_rd;
         void'(exp_q.pop_front());
      end
      check("cpu_rdata", cpu_rdata, last_rdata[0]);
      check("dbg_rdata", dbg_rdata, last_rdata[1]);
      if (cpu_ack) ack_log.push_back('{1'b0, cyc, cpu_rdata, cpu_err});
      if (dbg_ack) ack_log.push_back('{1'b1, cyc, dbg_rdata, dbg_err});
      if (mem_en) en_cnt++;
      if (mem_we) begin
         we_cnt++;
         last_we_addr = mem_addr;
      end
      cpu_acked = cpu_ack;
      dbg_acked = dbg_ack;
   endtask

   task automatic drive();
      if (cpu_req && cpu_acked && !hold_mode) cpu_req = 1'b0;
      else if (!cpu_req && rand_mode && $urandom_range(0, 2) == 0) begin
         cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1));
         cpu_addr = rand_addr(); cpu_wdata = $urandom;
      end
      if (dbg_req && dbg_acked && !hold_mode) dbg_req = 1'b0;
      else if (!dbg_req && rand_mode && $urandom_range(0, 2) == 0) begin
         dbg_req = 1'b1; dbg_we = 1'($urandom_range(0, 1));
         dbg_addr = rand_addr(); dbg_wdata = $urandom;
      end
   endtask

   // Arbiter rules: one transaction per three cycles, cpu preferred unless
   // the debug port has lost LIMIT contested rounds in a row.
   task automatic model();
      txn_t        t;
      bit          dbg_wins;
      logic [31:0] a;
      if (!dbg_req) starve = 0;
      if (cyc >= free_cyc && (cpu_req || dbg_req)) begin
         dbg_wins = dbg_req && (!cpu_req || starve == LIMIT);
         if (dbg_wins) starve = 0;
         else if (dbg_req && starve < LIMIT) starve++;
         a         = dbg_wins ? dbg_addr : cpu_addr;
         t.owner   = dbg_wins;
         t.we      = dbg_wins ? dbg_we : cpu_we;
         t.wdata   = dbg_wins ? dbg_wdata : cpu_wdata;
         t.err     = (a % 4 != 0) || (a >= 32'd256);
         t.idx     = a[7:2];
         t.ack_cyc = cyc + 2;
         exp_q.push_back(t);
         free_cyc  = cyc + 3;
      end
   endtask

   task automatic step();
      check_cycle();
      drive();
      #1;
      check("cpu_stall", cpu_stall, cpu_req && !exp_cpu_ack);
      model();
      @(posedge clock);
      @(negedge clock);
      cyc++;
   endtask

   task automatic drain(input int max);
      int n = 0;
      while ((exp_q.size() > 0 || cpu_req || dbg_req) && n < max) begin
         step();
         n++;
      end
      check("drain_busy", exp_q.size() + int'(cpu_req) + int'(dbg_req), 0);
      step();
   endtask

   task automatic preload(input int idx, input logic [31:0] data);
      pre_we = 1'b1; pre_idx = 6'(idx); pre_data = data;
      ref_mem[idx] = data;
      step();
      pre_we = 1'b0;
   endtask

   task automatic cpu_issue(input bit we, input logic [31:0] addr, input logic [31:0] wd);
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
   endtask

   task automatic dbg_issue(input bit we, input logic [31:0] addr, input logic [31:0] wd);
      dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wd;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      logic [31:0] old_w1;
      checks = 0; errors = 0; en_cnt = 0; we_cnt = 0; last_we_addr = '0;
      rand_mode = 0; hold_mode = 0; cpu_acked = 0; dbg_acked = 0; exp_cpu_ack = 0;
      last_rdata[0] = '0; last_rdata[1] = '0;
      // Fill memory while reset is held.
      @(negedge clock);
      for (int i = 0; i < DMEM_WORDS; i++) begin
         pre_we = 1'b1; pre_idx = 6'(i); pre_data = $urandom;
         ref_mem[i] = pre_data;
         @(posedge clock);
         @(negedge clock);
      end
      pre_we = 1'b0;
      check("rst_mem_en", mem_en, 0);
      check("rst_cpu_rdata", cpu_rdata, 0);
      reset = 1'b0;
      cyc = 0; free_cyc = 0; starve = 0;
      step();

      // Read after preload: ack two cycles after the request.
      preload(4, 32'hDEADBEEF);
      ack_log.delete(); c0 = cyc;
      cpu_issue(1'b0, 32'h10, 32'h0);
      drain(20);
      check("r036_acks", ack_log.size(), 1);
      if (ack_log.size() > 0) begin
         check("r036_lat", ack_log[0].cyc - c0, 2);
         check("r036_rdata", ack_log[0].rdata, 32'hDEADBEEF);
      end

      // Debug write then cpu read of the same word.
      we_cnt = 0; ack_log.delete();
      dbg_issue(1'b1, 32'h20, 32'h12345678);
      drain(20);
      cpu_issue(1'b0, 32'h20, 32'h0);
      drain(20);
      check("r037_we_cnt", we_cnt, 1);
      check("r037_we_addr", last_we_addr, 8);
      check("r037_rdata", cpu_rdata, 32'h12345678);

      // Illegal addresses: error ack, zero data, memory untouched.
      en_cnt = 0; ack_log.delete();
      cpu_issue(1'b0, 32'h102, 32'h0);
      drain(20);
      cpu_issue(1'b0, 32'h100, 32'h0);
      drain(20);
      check("r039_en_cnt", en_cnt, 0);
      check("r039_acks", ack_log.size(), 2);
      foreach (ack_log[i]) begin
         check("r039_err", ack_log[i].err, 1);
         check("r039_rdata", ack_log[i].rdata, 0);
      end

      // Both ports held: four cpu wins then one debug win, repeating.
      ack_log.delete();
      cpu_issue(1'b0, 32'h0, 32'h0);
      dbg_issue(1'b0, 32'h4, 32'h0);
      hold_mode = 1;
      repeat (30) step();
      hold_mode = 0;
      drain(40);
      check("r038_acks_ge10", ack_log.size() >= 10, 1);
      for (int i = 0; i < 10 && i < ack_log.size(); i++)
         check($sformatf("r038_owner%0d", i), ack_log[i].owner, (i % 5 == 4) ? 1 : 0);

      // cpu request appearing while debug transaction is in ACCESS.
      ack_log.delete();
      dbg_issue(1'b0, 32'h8, 32'h0);
      step();
      cpu_issue(1'b0, 32'hC, 32'h0);
      drain(20);
      check("r041_acks", ack_log.size(), 2);
      if (ack_log.size() == 2) begin
         check("r041_first", ack_log[0].owner, 1);
         check("r041_second", ack_log[1].owner, 0);
         check("r041_gap", ack_log[1].cyc - ack_log[0].cyc, 3);
      end

      // Reset during the ACCESS cycle of a debug write.
      old_w1 = ref_mem[1];
      ack_log.delete();
      dbg_issue(1'b1, 32'h4, 32'hA5A5A5A5);
      step();
      check_cycle();
      reset = 1'b1;
      dbg_req = 1'b0;
      #1;
      check("r040_mem_en", mem_en, 0);
      check("r040_mem_we", mem_we, 0);
      check("r040_state", fsm_state, 0);
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      cyc++;
      exp_q.delete(); starve = 0; free_cyc = cyc;
      last_rdata[0] = '0; last_rdata[1] = '0;
      check("r040_word1", mem[1], old_w1);
      check("r040_dbg_ack", dbg_ack, 0);
      check("r040_dbg_rdata", dbg_rdata, 0);
      dbg_issue(1'b0, 32'h4, 32'h0);
      drain(20);
      check("r040_acks", ack_log.size(), 1);
      if (ack_log.size() > 0) check("r040_rdata", ack_log[0].rdata, old_w1);

      // Random two-port traffic.
      rand_mode = 1;
      repeat (800) step();
      rand_mode = 0;
      drain(60);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
